memory_arbiter: RTL

Shares one single-port unified memory between the Fetch_Unit instruction interface (I-port) and the load/store data interface (D-port). Each requester drives the same memory-interface bundle that Fetch_Unit drives: enable, state, address, frame_mask. The arbiter grants one request at a time and waits a fixed memory latency. It then returns read data with a one-cycle done pulse. It sits between the core's fetch/memory stages and the memory model/SRAM.

---
 rtl/memory_arbiter_pkg.sv | 14 +
 rtl/memory_arbiter_if.sv | 28 ++
 rtl/memory_arbiter_select.sv | 23 ++
 rtl/memory_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter:
// access direction, FSM encodings and grant IDs.
package memory_arbiter_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester-side memory bundle, as driven by Fetch_Unit
// and the load/store stage.
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  enable;
  logic                  state;
  logic [ADDR_WIDTH-1:0] address;
  logic [3:0]            frame_mask;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  done;

  modport master (
    output enable, state, address,
    output frame_mask, data_out,
    input  data_in, done
  );

  modport slave (
    input  enable, state, address,
    input  frame_mask, data_out,
    output data_in, done
  );

endinterface

// File: rtl/memory_arbiter_select.sv
// Two-way grant selection: a lone eligible port wins,
// a tie goes to the port that was not served last.
module memory_arbiter_select
  import memory_arbiter_pkg::*;
(
  input  logic i_elig_i,
  input  logic d_elig_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic valid_o
);

  // pick the winner among eligible requesters
  always_comb begin
    valid_o = i_elig_i | d_elig_i;
    grant_o = GRANT_I;
    if (i_elig_i && d_elig_i)
      grant_o = ~last_grant_i;
    else if (d_elig_i)
      grant_o = GRANT_D;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between the I-port and
// D-port; one transaction at a time, fixed latency.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  reset,
  memory_arbiter_if.slave       i_port,
  memory_arbiter_if.slave       d_port,
  output logic                  mem_enable,
  output logic                  mem_state,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_frame_mask,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  localparam int CW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  men_q, men_d;
  logic                  mst_q, mst_d;
  logic [ADDR_WIDTH-1:0] madr_q, madr_d;
  logic [3:0]            mmsk_q, mmsk_d;
  logic [DATA_WIDTH-1:0] mwd_q, mwd_d;
  logic                  idone_q, idone_d;
  logic                  ddone_q, ddone_d;
  logic [DATA_WIDTH-1:0] irdat_q, irdat_d;
  logic [DATA_WIDTH-1:0] drdat_q, drdat_d;

  logic i_elig, d_elig;
  logic sel_grant, sel_valid;

  // a port in its done cycle is not re-served
  assign i_elig = i_port.enable & ~idone_q;
  assign d_elig = d_port.enable & ~ddone_q;

  memory_arbiter_select u_select (
    .i_elig_i     (i_elig),
    .d_elig_i     (d_elig),
    .last_grant_i (last_q),
    .grant_o      (sel_grant),
    .valid_o      (sel_valid)
  );

  // grant in IDLE, count down and complete in ACCESS
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    men_d   = men_q;
    mst_d   = mst_q;
    madr_d  = madr_q;
    mmsk_d  = mmsk_q;
    mwd_d   = mwd_q;
    idone_d = 1'b0;
    ddone_d = 1'b0;
    irdat_d = irdat_q;
    drdat_d = drdat_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d = ST_ACCESS;
          cnt_d   = CW'(MEM_LATENCY - 1);
          last_d  = sel_grant;
          men_d   = 1'b1;
          if (sel_grant == GRANT_D) begin
            mst_d  = d_port.state;
            madr_d = d_port.address;
            mmsk_d = d_port.frame_mask;
            mwd_d  = d_port.data_out;
          end else begin
            mst_d  = i_port.state;
            madr_d = i_port.address;
            mmsk_d = i_port.frame_mask;
            mwd_d  = i_port.data_out;
          end
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          men_d   = 1'b0;
          mst_d   = READ;
          madr_d  = '0;
          mmsk_d  = '0;
          mwd_d   = '0;
          if (last_q == GRANT_D) begin
            ddone_d = 1'b1;
            if (mst_q == READ)
              drdat_d = mem_data_in;
          end else begin
            idone_d = 1'b1;
            if (mst_q == READ)
              irdat_d = mem_data_in;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= GRANT_I;
      men_q   <= 1'b0;
      mst_q   <= READ;
      madr_q  <= '0;
      mmsk_q  <= '0;
      mwd_q   <= '0;
      idone_q <= 1'b0;
      ddone_q <= 1'b0;
      irdat_q <= '0;
      drdat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      men_q   <= men_d;
      mst_q   <= mst_d;
      madr_q  <= madr_d;
      mmsk_q  <= mmsk_d;
      mwd_q   <= mwd_d;
      idone_q <= idone_d;
      ddone_q <= ddone_d;
      irdat_q <= irdat_d;
      drdat_q <= drdat_d;
    end
  end

  assign mem_enable     = men_q;
  assign mem_state      = mst_q;
  assign mem_address    = madr_q;
  assign mem_frame_mask = mmsk_q;
  assign mem_data_out   = mwd_q;

  assign i_port.done    = idone_q;
  assign i_port.data_in = irdat_q;
  assign d_port.done    = ddone_q;
  assign d_port.data_in = drdat_q;

endmodule
